brt_queue: RTL and testbench

BRT_QUEUE -- requirements
Module: brt_queue

---
 rtl/brt_pkg.sv | 35 +++
 rtl/brt_queue_if.sv | 58 +++++
 rtl/brt_cam_match.sv | 32 +++
 rtl/brt_queue.sv | 162 ++++++++++++++++
 tb/tb_brt_queue.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brt_pkg.sv
// Shared types and defaults for the branch resolution queue.
package brt_pkg;

    localparam int BRT_DEPTH   = 16;
    localparam int BRT_ROBSIZE = 8;
    localparam int BRT_NRES    = 2;

    // Widest ROB tag an entry can hold. Narrower tags are zero-extended on
    // the way in, so ROBSIZE must not exceed this.
    localparam int BRT_ROBW    = 16;

    typedef struct packed {
        logic                valid;
        logic                resolved;
        logic [BRT_ROBW-1:0] rob;
        logic [31:0]         pc;
        logic [31:0]         target_pre;
        logic                taken_pre;
        logic [31:0]         target_cal;
        logic                taken_cal;
        logic                is_ret;
    } brt_entry_t;

    // Prediction was wrong in direction, or taken to the wrong place.
    function automatic logic brt_miss_pre(input brt_entry_t e);
        return (e.taken_cal != e.taken_pre) ||
               (e.taken_cal && (e.target_cal != e.target_pre));
    endfunction

    // Architecturally correct next PC for the branch.
    function automatic logic [31:0] brt_cal_target(input brt_entry_t e);
        return e.taken_cal ? e.target_cal : (e.pc + 32'd4);
    endfunction

endpackage

// File: rtl/brt_queue_if.sv
// Allocate / resolve / commit / predictor-update bundle of the branch queue.
interface brt_queue_if #(
    parameter int DEPTH   = 16,
    parameter int ROBSIZE = 8,
    parameter int NRES    = 2
);
    // allocate
    logic                        i_wr_en;
    logic [ROBSIZE-1:0]          i_wr_rob_addr;
    logic [31:0]                 i_wr_pc;
    logic [31:0]                 i_wr_target_pre;
    logic                        i_wr_taken_pre;
    logic                        i_wr_is_ret;
    logic                        o_full;
    logic                        o_empty;
    logic [$clog2(DEPTH):0]      o_count;
    // resolve
    logic [NRES-1:0]             i_res_v;
    logic [NRES*ROBSIZE-1:0]     i_res_rob_addr;
    logic [NRES-1:0]             i_res_taken;
    logic [NRES*32-1:0]          i_res_target;
    logic [NRES-1:0]             o_res_ack;
    // commit
    logic                        i_commit;
    logic [ROBSIZE-1:0]          i_commit_rob_addr;
    logic                        o_commit_done;
    logic                        o_commit_miss_pre;
    logic [31:0]                 o_commit_cal_target;
    // predictor update
    logic                        o_btb_write_en;
    logic [31:0]                 o_btb_write_pc;
    logic [31:0]                 o_btb_write_target;
    logic                        o_btb_write_is_ret;
    logic                        o_bht_write_en;
    logic [31:0]                 o_bht_write_pc;
    logic                        o_bht_write_taken;

    modport master (
        output i_wr_en, i_wr_rob_addr, i_wr_pc, i_wr_target_pre, i_wr_taken_pre, i_wr_is_ret,
        output i_res_v, i_res_rob_addr, i_res_taken, i_res_target,
        output i_commit, i_commit_rob_addr,
        input  o_full, o_empty, o_count, o_res_ack,
        input  o_commit_done, o_commit_miss_pre, o_commit_cal_target,
        input  o_btb_write_en, o_btb_write_pc, o_btb_write_target, o_btb_write_is_ret,
        input  o_bht_write_en, o_bht_write_pc, o_bht_write_taken
    );

    modport slave (
        input  i_wr_en, i_wr_rob_addr, i_wr_pc, i_wr_target_pre, i_wr_taken_pre, i_wr_is_ret,
        input  i_res_v, i_res_rob_addr, i_res_taken, i_res_target,
        input  i_commit, i_commit_rob_addr,
        output o_full, o_empty, o_count, o_res_ack,
        output o_commit_done, o_commit_miss_pre, o_commit_cal_target,
        output o_btb_write_en, o_btb_write_pc, o_btb_write_target, o_btb_write_is_ret,
        output o_bht_write_en, o_bht_write_pc, o_bht_write_taken
    );

endinterface

// File: rtl/brt_cam_match.sv
// One resolve channel's tag search over all queue entries; the lowest
// matching entry index wins if a tag is present more than once.
module brt_cam_match #(
    parameter int DEPTH = 16,
    parameter int TAGW  = 16,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0][TAGW-1:0] tags,
    input  logic                       req_v,
    input  logic [TAGW-1:0]            req_tag,
    output logic [DEPTH-1:0]           hit_oh,
    output logic                       hit,
    output logic [IW-1:0]              hit_idx
);

    // Scan high to low so the last (lowest) match overwrites earlier ones.
    always_comb begin
        hit_oh  = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_v && valid[i] && (tags[i] == req_tag)) begin
                hit       = 1'b1;
                hit_idx   = IW'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/brt_queue.sv
// Branch resolution queue: in-order allocate, out-of-order resolve by ROB
// tag on NRES channels, in-order commit with predictor update.
module brt_queue
    import brt_pkg::*;
#(
    parameter int DEPTH   = BRT_DEPTH,
    parameter int ROBSIZE = BRT_ROBSIZE,
    parameter int NRES    = BRT_NRES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_flush,
    brt_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    brt_entry_t                        ent [DEPTH];
    logic [PW-1:0]                     head;
    logic [PW-1:0]                     tail;
    logic [CW-1:0]                     count;

    logic [DEPTH-1:0]                  ent_v;
    logic [DEPTH-1:0][BRT_ROBW-1:0]    ent_rob;
    logic [NRES-1:0][BRT_ROBW-1:0]     res_tag;
    logic [NRES-1:0][31:0]             res_tgt;
    logic [NRES-1:0][DEPTH-1:0]        hit_oh;
    logic [NRES-1:0]                   hit;
    logic [NRES-1:0][PW-1:0]           hit_idx;
    logic [NRES-1:0]                   ack;
    logic [DEPTH-1:0]                  claimed;

    logic                              full;
    logic                              wr_ok;
    logic                              commit_ok;
    brt_entry_t                        head_e;

    assign full         = (count == CW'(DEPTH));
    assign wr_ok        = bus.i_wr_en && !full;
    assign bus.o_full   = full;
    assign bus.o_empty  = (count == '0);
    assign bus.o_count  = count;

    // Flatten entry state and unpack the per-channel resolve buses.
    always_comb begin
        ent_v   = '0;
        ent_rob = '0;
        res_tag = '0;
        res_tgt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            ent_v[e]   = ent[e].valid;
            ent_rob[e] = ent[e].rob;
        end
        for (int c = 0; c < NRES; c++) begin
            res_tag[c] = BRT_ROBW'(bus.i_res_rob_addr[c*ROBSIZE +: ROBSIZE]);
            res_tgt[c] = bus.i_res_target[c*32 +: 32];
        end
    end

    for (genvar c = 0; c < NRES; c++) begin : g_cam
        brt_cam_match #(
            .DEPTH (DEPTH),
            .TAGW  (BRT_ROBW)
        ) u_cam (
            .valid   (ent_v),
            .tags    (ent_rob),
            .req_v   (bus.i_res_v[c]),
            .req_tag (res_tag[c]),
            .hit_oh  (hit_oh[c]),
            .hit     (hit[c]),
            .hit_idx (hit_idx[c])
        );
    end

    // Lowest channel claims an entry; higher channels hitting it get no ack.
    // Acked channels therefore always target distinct entries.
    always_comb begin
        ack     = '0;
        claimed = '0;
        for (int c = 0; c < NRES; c++) begin
            ack[c] = hit[c] && ((hit_oh[c] & claimed) == '0);
            if (ack[c]) claimed = claimed | hit_oh[c];
        end
    end

    assign bus.o_res_ack = rstn ? ack : '0;

    // Head commit check and predictor-update outputs; zero unless committing.
    always_comb begin
        head_e    = ent[head];
        commit_ok = rstn && bus.i_commit && head_e.valid && head_e.resolved &&
                    (head_e.rob == BRT_ROBW'(bus.i_commit_rob_addr));

        bus.o_commit_done       = 1'b0;
        bus.o_commit_miss_pre   = 1'b0;
        bus.o_commit_cal_target = '0;
        bus.o_btb_write_en      = 1'b0;
        bus.o_btb_write_pc      = '0;
        bus.o_btb_write_target  = '0;
        bus.o_btb_write_is_ret  = 1'b0;
        bus.o_bht_write_en      = 1'b0;
        bus.o_bht_write_pc      = '0;
        bus.o_bht_write_taken   = 1'b0;
        if (commit_ok) begin
            bus.o_commit_done       = 1'b1;
            bus.o_commit_miss_pre   = brt_miss_pre(head_e);
            bus.o_commit_cal_target = brt_cal_target(head_e);
            bus.o_bht_write_en      = 1'b1;
            bus.o_bht_write_pc      = head_e.pc;
            bus.o_bht_write_taken   = head_e.taken_cal;
            if (head_e.taken_cal) begin
                bus.o_btb_write_en     = 1'b1;
                bus.o_btb_write_pc     = head_e.pc;
                bus.o_btb_write_target = head_e.target_cal;
                bus.o_btb_write_is_ret = head_e.is_ret;
            end
        end
    end

    // Queue state: flush behaves like reset; otherwise resolve, pop, push.
    // Resolve only touches valid entries and the pushed tail is never valid
    // when a write is accepted, so the three updates never collide except
    // resolve+pop on the head, where clearing valid is what matters.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent[e].valid    <= 1'b0;
                ent[e].resolved <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NRES; c++) begin
                if (ack[c]) begin
                    ent[hit_idx[c]].resolved   <= 1'b1;
                    ent[hit_idx[c]].taken_cal  <= bus.i_res_taken[c];
                    ent[hit_idx[c]].target_cal <= res_tgt[c];
                end
            end
            if (commit_ok) begin
                ent[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (wr_ok) begin
                ent[tail] <= '{valid:      1'b1,
                               resolved:   1'b0,
                               rob:        BRT_ROBW'(bus.i_wr_rob_addr),
                               pc:         bus.i_wr_pc,
                               target_pre: bus.i_wr_target_pre,
                               taken_pre:  bus.i_wr_taken_pre,
                               target_cal: 32'd0,
                               taken_cal:  1'b0,
                               is_ret:     bus.i_wr_is_ret};
                tail <= tail + 1'b1;
            end
            count <= count + CW'(wr_ok) - CW'(commit_ok);
        end
    end

endmodule

// File: tb/tb_brt_queue.sv
// Directed bench for brt_queue with a commit-order scoreboard.
module tb_brt_queue;

    localparam int DEPTH   = 16;
    localparam int ROBSIZE = 8;
    localparam int NRES    = 2;

    logic clk = 1'b0;
    logic rstn;
    logic i_flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    brt_queue_if #(.DEPTH(DEPTH), .ROBSIZE(ROBSIZE), .NRES(NRES)) bus ();

    brt_queue #(.DEPTH(DEPTH), .ROBSIZE(ROBSIZE), .NRES(NRES)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (i_flush),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  rob;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_wr_en           = 1'b0;
        bus.i_wr_rob_addr     = '0;
        bus.i_wr_pc           = '0;
        bus.i_wr_target_pre   = '0;
        bus.i_wr_taken_pre    = 1'b0;
        bus.i_wr_is_ret       = 1'b0;
        bus.i_res_v           = '0;
        bus.i_res_rob_addr    = '0;
        bus.i_res_taken       = '0;
        bus.i_res_target      = '0;
        bus.i_commit          = 1'b0;
        bus.i_commit_rob_addr = '0;
    endtask

    task automatic wr(input logic [7:0] rob, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic tk);
        bus.i_wr_en         = 1'b1;
        bus.i_wr_rob_addr   = rob;
        bus.i_wr_pc         = pc;
        bus.i_wr_target_pre = tgt;
        bus.i_wr_taken_pre  = tk;
        bus.i_wr_is_ret     = 1'b0;
    endtask

    task automatic res(input int c, input logic [7:0] rob, input logic tk,
                       input logic [31:0] tgt);
        bus.i_res_v[c]                = 1'b1;
        bus.i_res_rob_addr[c*8 +: 8]  = rob;
        bus.i_res_taken[c]            = tk;
        bus.i_res_target[c*32 +: 32]  = tgt;
    endtask

    task automatic cmt(input logic [7:0] rob);
        bus.i_commit          = 1'b1;
        bus.i_commit_rob_addr = rob;
    endtask

    initial begin
        rstn    = 1'b0;
        i_flush = 1'b0;
        idle();
        tick();
        tick();

        // Outputs held quiet while in reset, even with requests present.
        bus.i_commit = 1'b1;
        bus.i_res_v  = 2'b11;
        #1;
        chk("rst_empty", bus.o_empty, 1);
        chk("rst_full", bus.o_full, 0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_ack", bus.o_res_ack, 0);
        chk("rst_done", bus.o_commit_done, 0);
        chk("rst_bht_en", bus.o_bht_write_en, 0);
        chk("rst_btb_en", bus.o_btb_write_en, 0);
        idle();
        rstn = 1'b1;
        tick();

        // Correctly predicted taken branch.
        wr(8'd5, 32'h100, 32'h200, 1'b1);
        res(0, 8'd5, 1'b1, 32'h200);
        #1;
        chk("alloc_cycle_no_match", bus.o_res_ack, 0);
        tick();
        idle();
        cmt(8'd5);
        #1;
        chk("unresolved_commit", bus.o_commit_done, 0);
        res(0, 8'd5, 1'b1, 32'h200);
        #1;
        chk("r5_ack", bus.o_res_ack, 2'b01);
        chk("r5_same_cycle_commit", bus.o_commit_done, 0);
        tick();
        idle();
        cmt(8'd5);
        #1;
        chk("r5_done", bus.o_commit_done, 1);
        chk("r5_miss", bus.o_commit_miss_pre, 0);
        chk("r5_cal", bus.o_commit_cal_target, 32'h200);
        chk("r5_btb_en", bus.o_btb_write_en, 1);
        chk("r5_btb_pc", bus.o_btb_write_pc, 32'h100);
        chk("r5_btb_tgt", bus.o_btb_write_target, 32'h200);
        chk("r5_bht_en", bus.o_bht_write_en, 1);
        chk("r5_bht_taken", bus.o_bht_write_taken, 1);
        tick();
        idle();

        // Predicted taken, actually not taken.
        wr(8'd7, 32'h300, 32'h400, 1'b1);
        tick();
        idle();
        res(0, 8'd7, 1'b0, 32'h0);
        #1;
        chk("r7_ack", bus.o_res_ack, 2'b01);
        tick();
        idle();
        cmt(8'd7);
        #1;
        chk("r7_done", bus.o_commit_done, 1);
        chk("r7_miss", bus.o_commit_miss_pre, 1);
        chk("r7_cal", bus.o_commit_cal_target, 32'h304);
        chk("r7_btb_en", bus.o_btb_write_en, 0);
        chk("r7_bht_en", bus.o_bht_write_en, 1);
        chk("r7_bht_pc", bus.o_bht_write_pc, 32'h300);
        chk("r7_bht_taken", bus.o_bht_write_taken, 0);
        tick();
        idle();

        // Two channels on one entry plus a same-cycle commit.
        wr(8'd3, 32'h500, 32'h0, 1'b0);
        tick();
        idle();
        res(0, 8'd3, 1'b1, 32'h10);
        res(1, 8'd3, 1'b1, 32'h20);
        cmt(8'd3);
        #1;
        chk("r3_ack_prio", bus.o_res_ack, 2'b01);
        chk("r3_same_cycle_commit", bus.o_commit_done, 0);
        tick();
        idle();
        cmt(8'd3);
        #1;
        chk("r3_done", bus.o_commit_done, 1);
        chk("r3_cal", bus.o_commit_cal_target, 32'h10);
        chk("r3_miss", bus.o_commit_miss_pre, 1);
        chk("r3_btb_tgt", bus.o_btb_write_target, 32'h10);
        tick();
        idle();
        #1;
        chk("r3_count", bus.o_count, 0);

        // Fill from a non-zero tail position so both pointers wrap.
        for (int i = 0; i < 16; i++) begin
            e.rob = 8'(i);
            e.pc  = 32'h1000 + 32'(i) * 32'h10;
            sb.push_back(e);
            wr(e.rob, e.pc, 32'h0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("fill_full", bus.o_full, 1);
        chk("fill_count", bus.o_count, 16);
        wr(8'd20, 32'hdead, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("drop_count", bus.o_count, 16);
        res(0, 8'd20, 1'b1, 32'h0);
        #1;
        chk("drop_res_ack", bus.o_res_ack, 0);
        idle();

        for (int i = 0; i < 16; i += 2) begin
            res(0, 8'(i), 1'b0, 32'h0);
            res(1, 8'(i + 1), 1'b0, 32'h0);
            #1;
            chk("fill_res_ack", bus.o_res_ack, 2'b11);
            tick();
            idle();
        end

        cmt(8'd1);
        #1;
        chk("wrong_tag_commit", bus.o_commit_done, 0);
        idle();

        for (int k = 0; k < 16; k++) begin
            e = sb.pop_front();
            cmt(e.rob);
            if (k == 0) wr(8'd21, 32'hbeef, 32'h0, 1'b0);
            #1;
            chk("seq_done", bus.o_commit_done, 1);
            chk("seq_cal", bus.o_commit_cal_target, e.pc + 32'd4);
            chk("seq_bht_pc", bus.o_bht_write_pc, e.pc);
            tick();
            idle();
            if (k == 0) begin
                #1;
                chk("full_wr_commit_count", bus.o_count, 15);
            end
        end
        #1;
        chk("drain_empty", bus.o_empty, 1);
        chk("drain_count", bus.o_count, 0);

        for (int i = 0; i < 4; i++) begin
            e.rob = 8'(30 + i);
            e.pc  = 32'h2000 + 32'(i) * 32'h10;
            sb.push_back(e);
            wr(e.rob, e.pc, 32'h0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("wrap_count", bus.o_count, 4);
        chk("wrap_empty", bus.o_empty, 0);

        // Allocate and commit together leave the count unchanged.
        res(0, 8'd30, 1'b0, 32'h0);
        tick();
        idle();
        e = sb.pop_front();
        cmt(e.rob);
        wr(8'd34, 32'h2040, 32'h0, 1'b0);
        #1;
        chk("net0_done", bus.o_commit_done, 1);
        chk("net0_cal", bus.o_commit_cal_target, e.pc + 32'd4);
        tick();
        idle();
        #1;
        chk("net0_count", bus.o_count, 4);

        // Flush still shows the pre-flush commit, then empties.
        res(0, 8'd31, 1'b0, 32'h0);
        tick();
        idle();
        e = sb.pop_front();
        cmt(e.rob);
        wr(8'd40, 32'h3000, 32'h0, 1'b0);
        i_flush = 1'b1;
        #1;
        chk("flush_cycle_done", bus.o_commit_done, 1);
        tick();
        i_flush = 1'b0;
        idle();
        sb.delete();
        #1;
        chk("flush_empty", bus.o_empty, 1);
        chk("flush_count", bus.o_count, 0);

        // Reset in the middle of traffic.
        wr(8'd50, 32'h4000, 32'h0, 1'b0);
        tick();
        wr(8'd51, 32'h4010, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("pre_rst_count", bus.o_count, 2);
        rstn = 1'b0;
        wr(8'd52, 32'h4020, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("mid_rst_empty", bus.o_empty, 1);
        chk("mid_rst_count", bus.o_count, 0);
        rstn = 1'b1;
        tick();
        wr(8'd60, 32'h5000, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("post_rst_count", bus.o_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
